// File: rtl/proc_pkg.sv
// Shared processor definitions: register-address width, the XZR register
// number, and the write-back entry record held by wb_queue.
package proc_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] XZR = 5'd31;

  // Data field width of a stored entry; wb_queue DATA_W must not exceed it.
  localparam int XLEN = 64;

  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic [XLEN-1:0]   data;
  } wbEntry_t;

endpackage

// File: rtl/wb_queue_fwd.sv
// Forwarding lookup for wb_queue: searches the pending entries newest-first
// and returns the data of the newest entry whose destination matches.
// Only built when WB_QUEUE_FWD_EN is defined.
`ifdef WB_QUEUE_FWD_EN
module wb_queue_fwd
  import proc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic [REG_AW-1:0] lookupRa,
  input  wbEntry_t          entries [DEPTH],  // index 0 is the newest entry
  input  logic [DEPTH-1:0]  valid,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gMatch
      assign match[gi] = valid[gi] && (entries[gi].rw == lookupRa) && (lookupRa != XZR);
    end
  endgenerate

  // Priority select: scanning oldest to newest so the newest match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit  = 1'b1;
        data = DATA_W'(entries[k].data);
      end
    end
  end

endmodule
`endif

// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of {RW, data} entries that drains into the
// register-file write port whenever that port is free. State updates on the
// falling edge of Clk, the same edge the register file writes on.
// Optional macro WB_QUEUE_FWD_EN adds two combinational forwarding lookups.
module wb_queue
  import proc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [REG_AW-1:0]       InRW,
  input  logic [DATA_W-1:0]       InData,
  input  logic                    DrainEn,
  output logic                    RegWr,
  output logic [REG_AW-1:0]       RW,
  output logic [DATA_W-1:0]       BusW,
  output logic [$clog2(DEPTH):0]  Count
`ifdef WB_QUEUE_FWD_EN
  ,
  input  logic [REG_AW-1:0]       FwdRA,
  input  logic [REG_AW-1:0]       FwdRB,
  output logic                    FwdHitA,
  output logic                    FwdHitB,
  output logic [DATA_W-1:0]       FwdDataA,
  output logic [DATA_W-1:0]       FwdDataB
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbEntry_t          entryMem [DEPTH];
  logic [PTR_W-1:0]  headReg;
  logic [PTR_W-1:0]  tailReg;
  logic [CNT_W-1:0]  countReg;
  logic [CNT_W-1:0]  countNext;

  logic notEmpty;
  logic doPush;
  logic doStore;
  logic doPop;

  // Handshake: a full queue refuses even if it pops this cycle. Writes to XZR
  // complete the handshake but are dropped.
  assign notEmpty = (countReg != '0);
  assign InReady  = (countReg != CNT_W'(DEPTH));
  assign doPush   = InValid && InReady;
  assign doStore  = doPush && (InRW != XZR);
  assign doPop    = DrainEn && notEmpty;

  assign RegWr = doPop;
  assign RW    = notEmpty ? entryMem[headReg].rw : XZR;
  assign BusW  = notEmpty ? DATA_W'(entryMem[headReg].data) : '0;
  assign Count = countReg;

  // Occupancy after this cycle's store/pop pair.
  always_comb begin
    countNext = countReg;
    case ({doStore, doPop})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
    end else begin
      if (doStore) tailReg <= tailReg + PTR_W'(1);
      if (doPop)   headReg <= headReg + PTR_W'(1);
      countReg <= countNext;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(negedge Clk) begin
    if (doStore) begin
      entryMem[tailReg] <= '{rw: InRW, data: XLEN'(InData)};
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Entries re-ordered newest-first for the forwarding search.
  wbEntry_t         ageEntries [DEPTH];
  logic [DEPTH-1:0] ageValid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gAge
      assign ageEntries[gi] = entryMem[tailReg - PTR_W'(gi + 1)];
      assign ageValid[gi]   = (CNT_W'(gi) < countReg);
    end
  endgenerate

  wb_queue_fwd #(.DEPTH(DEPTH), .DATA_W(DATA_W)) fwdA (
    .lookupRa (FwdRA),
    .entries  (ageEntries),
    .valid    (ageValid),
    .hit      (FwdHitA),
    .data     (FwdDataA)
  );

  wb_queue_fwd #(.DEPTH(DEPTH), .DATA_W(DATA_W)) fwdB (
    .lookupRa (FwdRB),
    .entries  (ageEntries),
    .valid    (ageValid),
    .hit      (FwdHitB),
    .data     (FwdDataB)
  );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue (DEPTH=4, DATA_W=64). Inputs change just
// after the falling edge, outputs are sampled on the rising edge.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InRW;
  logic [63:0] InData;
  logic        DrainEn;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [2:0]  Count;
`ifdef WB_QUEUE_FWD_EN
  logic [4:0]  FwdRA;
  logic [4:0]  FwdRB;
  logic        FwdHitA;
  logic        FwdHitB;
  logic [63:0] FwdDataA;
  logic [63:0] FwdDataB;
`endif

  int tests;
  int failed;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .InValid (InValid),
    .InReady (InReady),
    .InRW    (InRW),
    .InData  (InData),
    .DrainEn (DrainEn),
    .RegWr   (RegWr),
    .RW      (RW),
    .BusW    (BusW),
    .Count   (Count)
`ifdef WB_QUEUE_FWD_EN
    ,
    .FwdRA    (FwdRA),
    .FwdRB    (FwdRB),
    .FwdHitA  (FwdHitA),
    .FwdHitB  (FwdHitB),
    .FwdDataA (FwdDataA),
    .FwdDataB (FwdDataB)
`endif
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rstN;
    logic        inValid;
    logic [4:0]  inRw;
    logic [63:0] inData;
    logic        drainEn;
    logic        expReady;
    logic        expRegWr;
    logic [4:0]  expRw;
    logic [63:0] expBusW;
    logic [2:0]  expCount;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic v, input int rw, input logic [63:0] d,
                              input logic de, input logic eRdy, input logic eWr, input int eRw,
                              input logic [63:0] eBus, input int eCnt);
    vec_t t;
    t.rstN = r; t.inValid = v; t.inRw = 5'(rw); t.inData = d; t.drainEn = de;
    t.expReady = eRdy; t.expRegWr = eWr; t.expRw = 5'(eRw); t.expBusW = eBus;
    t.expCount = 3'(eCnt);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge Clk);
    #1;
  endtask

  logic [68:0] model [$];
  logic [68:0] front;

  initial begin
    tests = 0; failed = 0;
    Rst_n = 1'b0; InValid = 1'b0; InRW = 5'd0; InData = 64'd0; DrainEn = 1'b0;
`ifdef WB_QUEUE_FWD_EN
    FwdRA = 5'd0; FwdRB = 5'd0;
`endif

    //            rst v  rw  data    de  rdy wr rw  busw    cnt
    // single push then drain with one cycle latency
    vecs[0]  = mk(1, 1, 3,  64'h11,  1,  1, 0, 31, 64'h0,   0);
    vecs[1]  = mk(1, 0, 0,  64'h0,   1,  1, 1, 3,  64'h11,  1);
    vecs[2]  = mk(1, 0, 0,  64'h0,   0,  1, 0, 31, 64'h0,   0);
    // fill with drain held off; fifth offer refused
    vecs[3]  = mk(1, 1, 1,  64'h101, 0,  1, 0, 31, 64'h0,   0);
    vecs[4]  = mk(1, 1, 2,  64'h102, 0,  1, 0, 0,  64'h0,   1);
    vecs[5]  = mk(1, 1, 3,  64'h103, 0,  1, 0, 0,  64'h0,   2);
    vecs[6]  = mk(1, 1, 4,  64'h104, 0,  1, 0, 0,  64'h0,   3);
    vecs[7]  = mk(1, 1, 5,  64'h105, 0,  0, 0, 0,  64'h0,   4);
    // full with a pop this cycle: still not ready
    vecs[8]  = mk(1, 1, 5,  64'h105, 1,  0, 1, 1,  64'h101, 4);
    vecs[9]  = mk(1, 0, 0,  64'h0,   1,  1, 1, 2,  64'h102, 3);
    vecs[10] = mk(1, 0, 0,  64'h0,   1,  1, 1, 3,  64'h103, 2);
    vecs[11] = mk(1, 0, 0,  64'h0,   1,  1, 1, 4,  64'h104, 1);
    vecs[12] = mk(1, 0, 0,  64'h0,   1,  1, 0, 31, 64'h0,   0);
    // write to XZR is accepted and dropped
    vecs[13] = mk(1, 1, 31, 64'hFF,  1,  1, 0, 31, 64'h0,   0);
    vecs[14] = mk(1, 0, 0,  64'h0,   1,  1, 0, 31, 64'h0,   0);
    // fill three, start draining, reset mid-drain (push offered during reset)
    vecs[15] = mk(1, 1, 6,  64'h201, 0,  1, 0, 31, 64'h0,   0);
    vecs[16] = mk(1, 1, 7,  64'h202, 0,  1, 0, 0,  64'h0,   1);
    vecs[17] = mk(1, 1, 8,  64'h203, 0,  1, 0, 0,  64'h0,   2);
    vecs[18] = mk(1, 1, 9,  64'h204, 1,  1, 1, 6,  64'h201, 3);
    vecs[19] = mk(0, 1, 10, 64'h205, 1,  1, 1, 7,  64'h202, 3);
    vecs[20] = mk(1, 0, 0,  64'h0,   1,  1, 0, 31, 64'h0,   0);

    // reset for two edges, then check the idle state
    nextCycle();
    nextCycle();
    Rst_n = 1'b1; DrainEn = 1'b1;
    @(posedge Clk);
    $display("[TB] reset: ready=%b wr=%b RW=%0d BusW=%0h cnt=%0d", InReady, RegWr, RW, BusW, Count);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_regwr", 64'(RegWr), 64'd0);
    chk("rst_ready", 64'(InReady), 64'd1);
    chk("rst_rw",    64'(RW), 64'd31);
    chk("rst_busw",  BusW, 64'd0);
    nextCycle();

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      Rst_n = vecs[i].rstN; InValid = vecs[i].inValid; InRW = vecs[i].inRw;
      InData = vecs[i].inData; DrainEn = vecs[i].drainEn;
      @(posedge Clk);
      $display("[TB] vec %0d rst=%b v=%b rw=%0d de=%b -> ready=%b wr=%b RW=%0d BusW=%0h cnt=%0d",
               i, Rst_n, InValid, InRW, DrainEn, InReady, RegWr, RW, BusW, Count);
      chk($sformatf("vec%0d_ready", i), 64'(InReady), 64'(vecs[i].expReady));
      chk($sformatf("vec%0d_regwr", i), 64'(RegWr),   64'(vecs[i].expRegWr));
      chk($sformatf("vec%0d_count", i), 64'(Count),   64'(vecs[i].expCount));
      if (vecs[i].expRegWr || vecs[i].expCount == 3'd0) begin
        chk($sformatf("vec%0d_rw", i),   64'(RW), 64'(vecs[i].expRw));
        chk($sformatf("vec%0d_busw", i), BusW,    vecs[i].expBusW);
      end
      nextCycle();
    end

    // pointer wrap: two queued, then simultaneous push+pop, then drain
    Rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      InValid = 1'b1; InRW = 5'(10 + i); InData = 64'h300 + 64'(i); DrainEn = (i >= 2);
      @(posedge Clk);
      $display("[TB] wrap %0d push rw=%0d de=%b -> wr=%b RW=%0d BusW=%0h cnt=%0d",
               i, InRW, DrainEn, RegWr, RW, BusW, Count);
      chk("wrap_ready", 64'(InReady), 64'd1);
      chk("wrap_count", 64'(Count), (i < 2) ? 64'(i) : 64'd2);
      if (i >= 2) begin
        front = model[0];
        chk("wrap_regwr", 64'(RegWr), 64'd1);
        chk("wrap_rw",    64'(RW), 64'(front[68:64]));
        chk("wrap_busw",  BusW, front[63:0]);
        void'(model.pop_front());
      end
      model.push_back({InRW, InData});
      nextCycle();
    end
    for (int i = 0; i < 2; i++) begin
      InValid = 1'b0; DrainEn = 1'b1;
      @(posedge Clk);
      $display("[TB] wrap drain %0d -> wr=%b RW=%0d BusW=%0h cnt=%0d", i, RegWr, RW, BusW, Count);
      front = model[0];
      chk("wrapd_regwr", 64'(RegWr), 64'd1);
      chk("wrapd_rw",    64'(RW), 64'(front[68:64]));
      chk("wrapd_busw",  BusW, front[63:0]);
      void'(model.pop_front());
      nextCycle();
    end
    @(posedge Clk);
    chk("wrap_empty", 64'(Count), 64'd0);
    nextCycle();

`ifdef WB_QUEUE_FWD_EN
    // forwarding: two writes to r7, newest value must be returned
    DrainEn = 1'b0; InValid = 1'b1; InRW = 5'd7; InData = 64'hA;
    nextCycle();
    InData = 64'hB;
    nextCycle();
    InValid = 1'b0; FwdRA = 5'd7; FwdRB = 5'd31;
    @(posedge Clk);
    $display("[TB] fwd A=%0d hit=%b data=%0h B=%0d hit=%b data=%0h",
             FwdRA, FwdHitA, FwdDataA, FwdRB, FwdHitB, FwdDataB);
    chk("fwd_hitA",  64'(FwdHitA), 64'd1);
    chk("fwd_dataA", FwdDataA, 64'hB);
    chk("fwd_hitB_xzr",  64'(FwdHitB), 64'd0);
    chk("fwd_dataB_xzr", FwdDataB, 64'd0);
    nextCycle();
    FwdRB = 5'd5;
    @(posedge Clk);
    $display("[TB] fwd B=%0d hit=%b data=%0h", FwdRB, FwdHitB, FwdDataB);
    chk("fwd_hitB_miss",  64'(FwdHitB), 64'd0);
    chk("fwd_dataB_miss", FwdDataB, 64'd0);
    nextCycle();
    // after the older r7 drains, the newer one is still forwarded
    DrainEn = 1'b1;
    nextCycle();
    DrainEn = 1'b0; FwdRB = 5'd7;
    @(posedge Clk);
    $display("[TB] fwd after pop B=%0d hit=%b data=%0h cnt=%0d", FwdRB, FwdHitB, FwdDataB, Count);
    chk("fwd_hitB_pop",  64'(FwdHitB), 64'd1);
    chk("fwd_dataB_pop", FwdDataB, 64'hB);
    nextCycle();
    DrainEn = 1'b1;
    nextCycle();
    DrainEn = 1'b0;
    @(posedge Clk);
    chk("fwd_hitA_empty", 64'(FwdHitA), 64'd0);
    nextCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of pending write-back entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 64, meaning the write-back data width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state SHALL update on its negative edge, matching the register-file write edge.
REQ-004 SHALL have port Rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have port InValid, input, 1, meaning the producer offers a write-back.
REQ-006 SHALL have port InReady, output, 1, meaning the queue accepts an entry this cycle.
REQ-007 SHALL have port InRW, input, 5, meaning the destination register number.
REQ-008 SHALL have port InData, input, DATA_W, meaning the write-back value.
REQ-009 SHALL have port DrainEn, input, 1, meaning the register-file write port is free this cycle.
REQ-010 SHALL have port RegWr, output, 1, meaning the register-file write enable.
REQ-011 SHALL have port RW, output, 5, meaning the register-file write address.
REQ-012 SHALL have port BusW, output, DATA_W, meaning the register-file write data.
REQ-013 SHALL have port Count, output, clog2(DEPTH)+1, meaning the occupancy.

Function
REQ-014 SHALL implement a circular FIFO of {RW, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-015 SHALL drive InReady = (Count != DEPTH); a push SHALL occur when InValid && InReady.
REQ-016 SHALL discard a push with InRW == 31 (XZR): handshake completes, nothing is stored, Count is unchanged.
REQ-017 SHALL drive RegWr = DrainEn && (Count != 0) combinationally; when RegWr is high, RW and BusW SHALL equal the head entry, and the head SHALL pop at the clock edge.
REQ-018 SHALL drive RW = 31 and BusW = 0 while the queue is empty.
REQ-019 SHALL give a minimum latency of 1 cycle from push to RegWr, with no empty-queue pass-through.
REQ-020 SHALL, when a push and a pop occur in the same cycle, leave Count unchanged and advance both pointers; when full, InReady = 0 even if a pop occurs that cycle.
REQ-021 SHALL drain entries strictly in push order, so that later writes to the same RW win.

Reset
REQ-022 SHALL, while Rst_n = 0 at a clock edge, set head, tail, and Count to 0; all pending entries SHALL be dropped, including during a mid-drain, and RegWr SHALL be 0 from that edge.
REQ-023 SHALL NOT initialise stored data to any required value.

Configuration
REQ-024 SHALL, when WB_QUEUE_FWD_EN is defined, add inputs FwdRA[4:0] and FwdRB[4:0] and outputs FwdHitA, FwdHitB, FwdDataA, and FwdDataB.
REQ-025 SHALL, with WB_QUEUE_FWD_EN, assert FwdHitX when a valid entry matches FwdRX, with FwdDataX taken from the newest matching entry (combinational); FwdRX == 31 SHALL never hit, and a miss SHALL drive FwdDataX = 0.
REQ-026 SHALL, without WB_QUEUE_FWD_EN, omit these ports and the match logic entirely.

Structure
REQ-027 SHALL place the XZR register number (31), the register-address width (5), and the entry struct typedef {rw, data} in shared package proc_pkg.
REQ-028 SHALL place forwarding match logic in sub-module wb_queue_fwd (newest-first priority search), instantiated once per lookup port.

Verification
REQ-029 SHALL cover: push RW=3/0x11, DrainEn=1 -> next cycle RegWr=1, RW=3, BusW=0x11, then Count=0.
REQ-030 SHALL cover: DrainEn=0, push 5 entries -> the first 4 accepted, InReady=0 on the 5th, Count=4; DrainEn=1 -> drains in order over 4 cycles.
REQ-031 SHALL cover: push RW=31/0xFF -> InReady=1, Count stays 0, RegWr never asserted.
REQ-032 SHALL cover: Count=2 with simultaneous push and pop -> Count stays 2, order preserved across pointer wrap (DEPTH+2 pushes).
REQ-033 SHALL cover: with WB_QUEUE_FWD_EN, queue RW=7/0xA then RW=7/0xB, FwdRA=7 -> FwdHitA=1, FwdDataA=0xB; FwdRB=31 -> FwdHitB=0.
REQ-034 SHALL cover: Rst_n=0 for one edge with Count=3 mid-drain -> Count=0, RegWr=0, InReady=1 at the next cycle.
